// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier controller for the execute stage.
// It has no adder of its own. It drives the shared 64-bit ALU with the
// accumulator and the current partial product. It captures the ALU result
// once per iteration and produces the low WIDTH bits of the unsigned product.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | waiting for start; operands are captured on the accepting edge
// RUN    | one add/shift iteration per cycle; exits early once mplr drains
// DONE   | single-cycle done pulse; product is valid from this cycle onward
`timescale 1ns/1ps
module alu_mul_sequencer #(
  parameter int          WIDTH   = 64,
  parameter logic [3:0]  ALU_ADD = 4'b0010,
  parameter int          CNT_W   = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Iteration index at which RUN must stop, even if multiplier bits remain.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] product_q, product_d;

  logic             run_last;

  // Last iteration: no set bits remain above bit 0, or the width is exhausted.
  assign run_last = ((mplr_q >> 1) == '0) || (cnt_q == CNT_LAST);

  // Drive the ALU. The accumulator always feeds a. The partial product feeds
  // b only in RUN, so the ALU sees a zero addend while this block is idle.
  always_comb begin
    alu_a  = acc_q;
    alu_b  = '0;
    alu_op = ALU_ADD;
    if ((state_q == S_RUN) && mplr_q[0]) begin
      alu_b = mcand_q;
    end
  end

  // Next-state and datapath update. Each step captures the ALU sum, so the
  // product register is loaded with the value acc is about to take.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          mcand_d = multiplicand;
          mplr_d  = multiplier;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d   = alu_result;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (run_last) begin
          product_d = alu_result;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset takes priority and abandons any
  // operation in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplr_q    <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // Handshake outputs come from registered state only. This keeps start off
  // any combinational path to busy or done.
  always_comb begin
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
    product = product_q;
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
`timescale 1ns/1ps
module tb_alu_mul_sequencer;

  localparam int         WIDTH   = 64;
  localparam logic [3:0] ALU_ADD = 4'b0010;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_result;

  int n_cmp;
  int n_fail;

  alu_mul_sequencer #(.WIDTH(WIDTH), .ALU_ADD(ALU_ADD), .CNT_W(7)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_result   (alu_result)
  );

  // Stand-in for the execute-stage ALU. It is a zero-latency adder and ignores
  // alu_op.
  assign alu_result = alu_a + alu_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: number of RUN cycles from the multiplier's highest set bit.
  function automatic int ref_k(input logic [WIDTH-1:0] b);
    int k;
    k = 1;
    for (int i = 0; i < WIDTH; i++) if (b[i]) k = i + 1;
    return k;
  endfunction

  // Reference model: low WIDTH bits of the unsigned product.
  function automatic logic [WIDTH-1:0] ref_prod(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    r = a * b;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one multiply and collect the observations.
  // lat counts edges from the accepting edge to the first cycle with done high.
  // The busy and done values are sampled in the cycle after done.
  task automatic run_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         output int lat, output logic [WIDTH-1:0] prod,
                         output logic busy_after, output logic done_after);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    multiplicand = '1;
    multiplier   = '1;
    lat = 1;
    while (!done && lat < 200) begin
      tick();
      lat++;
    end
    prod = product;
    tick();
    busy_after = busy;
    done_after = done;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    tick();
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy got=%0b exp=0", busy);
    end
    n_cmp++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_done got=%0b exp=0", done);
    end
    n_cmp++;
    if (product !== '0) begin
      n_fail++;
      $display("FAIL reset_product got=%h exp=0", product);
    end
    n_cmp++;
    if (alu_a !== '0 || alu_b !== '0) begin
      n_fail++;
      $display("FAIL reset_alu_ab got a=%h b=%h exp 0/0", alu_a, alu_b);
    end
    n_cmp++;
    if (alu_op !== ALU_ADD) begin
      n_fail++;
      $display("FAIL reset_alu_op got=%b exp=%b", alu_op, ALU_ADD);
    end
    reset = 1'b1;
    tick();
  endtask

  // Directed cases: operands followed by the expected product and latency.
  task automatic test_directed();
    logic [WIDTH-1:0] ta[5];
    logic [WIDTH-1:0] tb_[5];
    logic [WIDTH-1:0] tp[5];
    int               tk[5];
    int lat;
    logic [WIDTH-1:0] prod;
    logic ba, da;
    ta[0] = 64'd6;                  tb_[0] = 64'd7;                  tp[0] = 64'd42;                  tk[0] = 3;
    ta[1] = 64'h1234;               tb_[1] = 64'd0;                  tp[1] = 64'd0;                   tk[1] = 1;
    ta[2] = 64'hFFFF_FFFF_FFFF_FFFF; tb_[2] = 64'd3;                  tp[2] = 64'hFFFF_FFFF_FFFF_FFFD; tk[2] = 2;
    ta[3] = 64'd3;                  tb_[3] = 64'hFFFF_FFFF_FFFF_FFFF; tp[3] = 64'hFFFF_FFFF_FFFF_FFFD; tk[3] = 64;
    ta[4] = 64'h1_0000_0000;        tb_[4] = 64'h1_0000_0000;        tp[4] = 64'd0;                   tk[4] = 33;
    for (int i = 0; i < 5; i++) begin
      run_mul(ta[i], tb_[i], lat, prod, ba, da);
      n_cmp++;
      if (lat !== tk[i] + 1) begin
        n_fail++;
        $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, tk[i] + 1);
      end
      n_cmp++;
      if (prod !== tp[i]) begin
        n_fail++;
        $display("FAIL dir%0d_product got=%h exp=%h", i, prod, tp[i]);
      end
      n_cmp++;
      if (ba !== 1'b0 || da !== 1'b0) begin
        n_fail++;
        $display("FAIL dir%0d_after_done got busy=%0b done=%0b exp 0/0", i, ba, da);
      end
      n_cmp++;
      if (product !== tp[i] || alu_b !== '0) begin
        n_fail++;
        $display("FAIL dir%0d_idle_hold got product=%h alu_b=%h exp %h/0", i, product, alu_b, tp[i]);
      end
    end
  endtask

  // Randomized back-to-back issues, each started in the first IDLE cycle.
  task automatic test_back_to_back();
    logic [WIDTH-1:0] a, b;
    int lat;
    logic [WIDTH-1:0] prod;
    logic ba, da;
    for (int i = 0; i < 24; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom} >> $urandom_range(0, 63);
      run_mul(a, b, lat, prod, ba, da);
      n_cmp++;
      if (lat !== ref_k(b) + 1) begin
        n_fail++;
        $display("FAIL rnd%0d_latency b=%h got=%0d exp=%0d", i, b, lat, ref_k(b) + 1);
      end
      n_cmp++;
      if (prod !== ref_prod(a, b)) begin
        n_fail++;
        $display("FAIL rnd%0d_product a=%h b=%h got=%h exp=%h", i, a, b, prod, ref_prod(a, b));
      end
      n_cmp++;
      if (ba !== 1'b0 || da !== 1'b0) begin
        n_fail++;
        $display("FAIL rnd%0d_after_done got busy=%0b done=%0b exp 0/0", i, ba, da);
      end
    end
  endtask

  // A start while busy is dropped. A mid-run reset abandons the operation.
  task automatic test_ignore_and_abort();
    int lat;
    int pulses;
    logic [WIDTH-1:0] prod;
    logic ba, da;
    multiplicand = 64'd11;
    multiplier   = 64'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    multiplicand = 64'd99;
    multiplier   = 64'd77;
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    lat = 5;
    while (!done && lat < 200) begin
      tick();
      lat++;
    end
    n_cmp++;
    if (lat !== 9) begin
      n_fail++;
      $display("FAIL ignore_latency got=%0d exp=9", lat);
    end
    n_cmp++;
    if (product !== 64'd2805) begin
      n_fail++;
      $display("FAIL ignore_product got=%0d exp=2805", product);
    end
    tick();
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) pulses++;
    end
    n_cmp++;
    if (busy !== 1'b0 || pulses !== 0) begin
      n_fail++;
      $display("FAIL ignore_not_queued got busy=%0b pulses=%0d exp 0/0", busy, pulses);
    end

    multiplicand = 64'd9;
    multiplier   = 64'hFFFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
      n_fail++;
      $display("FAIL abort_state got busy=%0b done=%0b product=%h exp 0/0/0", busy, done, product);
    end
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done || busy) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL abort_no_done got active_cycles=%0d exp=0", pulses);
    end

    run_mul(64'd5, 64'd5, lat, prod, ba, da);
    n_cmp++;
    if (prod !== 64'd25 || lat !== 4) begin
      n_fail++;
      $display("FAIL post_abort got product=%0d lat=%0d exp 25/4", prod, lat);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_ignore_and_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
- Multi-cycle controller that computes a 64-bit unsigned product (low 64 bits) by repeated shift-and-add.
- Owns no adder: it drives the existing 64-bit ALU's a/b/ALUop inputs and captures its Result each cycle.
- Sits beside the ALU in the execute stage and is used for MUL-class instructions.
- Handshake toward the pipeline: start pulse in, busy/done/product out.

Parameters:
WIDTH, 64, operand/product width; must match ALU width
ALU_ADD, 4'b0010, ALUop code driven for every add step
CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-low; sampled on rising edge of clk
start  input  1  request pulse; accepted only in IDLE
multiplicand  input  WIDTH  operand A; sampled when start is accepted
multiplier  input  WIDTH  operand B; sampled when start is accepted
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse in DONE; product valid from this cycle
product  output  WIDTH  result; held stable until next accepted start
alu_a  output  WIDTH  to ALU a; always equals the accumulator register
alu_b  output  WIDTH  to ALU b; mcand register if mplr[0]=1, else 0 (RUN only)
alu_op  output  4  to ALU ALUop; constant ALU_ADD
alu_result  input  WIDTH  from ALU Result; combinational function of alu_a/alu_b

Behaviour:
- Registers: state, acc, mcand, mplr, cnt.
- State encoding is IDLE, RUN, DONE.
- Reset (reset==0 at a rising edge):
  - state=IDLE, acc=0, mcand=0, mplr=0, cnt=0.
  - busy=0, done=0, product=0.
  - Reset has priority over everything; an operation in progress is abandoned with no done pulse.
- IDLE:
  - alu_b=0.
  - If start=1: acc<=0, mcand<=multiplicand, mplr<=multiplier, cnt<=0, go RUN.
- RUN, one iteration per cycle:
  - acc<=alu_result (acc + (mplr[0] ? mcand : 0)).
  - mcand<=mcand<<1.
  - mplr<=mplr>>1.
  - cnt<=cnt+1.
- RUN exit: go DONE when (mplr>>1)==0 or cnt==WIDTH-1; otherwise stay in RUN.
- RUN cycle count:
  - k = max(1, index of highest set bit of multiplier + 1).
  - multiplier=0 gives exactly 1 RUN cycle.
  - Maximum is WIDTH cycles.
- DONE:
  - Lasts exactly 1 cycle; done=1 and busy=1.
  - product reflects the final acc in this cycle.
  - Next state is always IDLE.
- Latency: start accepted at edge N -> RUN during cycles N+1..N+k -> done high in cycle N+k+1 -> IDLE in cycle N+k+2.
- product register: loaded from acc on the RUN->DONE transition; unchanged in IDLE.
- Arithmetic:
  - Unsigned, modulo 2^WIDTH.
  - Carries and shifted-out mcand bits are discarded; no overflow flag.
- start handling:
  - start while busy (RUN or DONE) is ignored and not queued.
  - Operands are sampled only at acceptance; later input changes have no effect.
- Back-to-back: start may be asserted in the first IDLE cycle after DONE; minimum issue interval is k+2 cycles.
- ALU assumptions: the ALU is purely combinational with zero latency, and alu_result is consumed in the same cycle it is driven.
- No combinational path from start to busy/done; all outputs except alu_a/alu_b are registered or decoded from state.

Test Plan:
- Reset, then start with multiplicand=6, multiplier=7 -> 3 RUN cycles; done in cycle N+4 with product=42; busy low in cycle N+5.
- multiplicand=0x1234, multiplier=0 -> 1 RUN cycle; done in cycle N+2; product=0.
- multiplicand=0xFFFF_FFFF_FFFF_FFFF, multiplier=3 -> product=0xFFFF_FFFF_FFFF_FFFD after 2 RUN cycles.
- multiplicand=3, multiplier=0xFFFF_FFFF_FFFF_FFFF -> 64 RUN cycles; product=0xFFFF_FFFF_FFFF_FFFD.
- multiplicand=2^32, multiplier=2^32 -> 33 RUN cycles; product=0 (truncation).
- start=1 with new operands during RUN -> ignored, first product unchanged. Then reset=0 for one cycle mid-RUN -> busy=0, done never pulses, product=0. The next start (5*5) yields 25.
